// File: rtl/audio_pkg.sv
// Shared types and constants for the audio sample scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package audio_pkg;

    localparam int SAMPLE_W = 24;

    typedef logic [SAMPLE_W-1:0] sample_t;

    typedef struct packed {
        sample_t left;
        sample_t right;
    } stereo_t;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START_L = 3'd1;
    localparam logic [2:0] S_WAIT_L  = 3'd2;
    localparam logic [2:0] S_START_R = 3'd3;
    localparam logic [2:0] S_WAIT_R  = 3'd4;
    localparam logic [2:0] S_PUSH    = 3'd5;

    typedef enum logic [2:0] {
        IDLE    = S_IDLE,
        START_L = S_START_L,
        WAIT_L  = S_WAIT_L,
        START_R = S_START_R,
        WAIT_R  = S_WAIT_R,
        PUSH    = S_PUSH
    } sched_state_t;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/sample_pair_fifo.sv
// Synchronous FIFO of stereo pairs with registered pointers and level.
// Latency: push visible at head/level the cycle after the push edge.
// Backpressure: push ignored when full unless a pop frees a slot that cycle.
module sample_pair_fifo
    import audio_pkg::*;
#(
    parameter type T     = stereo_t,
    parameter int  DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  T                         push_dat,
    input  logic                     pop,
    output T                         head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign level    = count;
    assign head_dat = mem[rd_ptr];

    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/audio_sample_sched.sv
// Sequences codec stereo samples through one shared FIR engine and buffers results for the DAC.
// Latency: bypass read->push 1 cycle; filtered read->push 3+2*Lf cycles.
// Backpressure: full FIFO drops the pair (overrun); empty FIFO feeds zeros (underrun).
module audio_sample_sched
    import audio_pkg::*;
#(
    parameter int DATA_W     = SAMPLE_W,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_WAIT   = 255
) (
    input  logic                          CLOCK_50,
    input  logic                          reset,
    input  logic                          read_ready,
    input  logic [DATA_W-1:0]             readdata_left,
    input  logic [DATA_W-1:0]             readdata_right,
    output logic                          read,
    input  logic                          write_ready,
    output logic                          write,
    output logic [DATA_W-1:0]             writedata_left,
    output logic [DATA_W-1:0]             writedata_right,
    input  logic                          bypass,
    output logic                          filt_start,
    output logic                          filt_sel,
    output logic [DATA_W-1:0]             filt_in,
    input  logic                          filt_done,
    input  logic [DATA_W-1:0]             filt_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overrun,
    output logic                          underrun,
    output logic                          filt_fault
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef struct packed {
        logic [DATA_W-1:0] left;
        logic [DATA_W-1:0] right;
    } pair_t;

    logic [2:0]         state_q;
    logic [DATA_W-1:0]  smp_l_q;
    logic [DATA_W-1:0]  smp_r_q;
    logic [DATA_W-1:0]  res_l_q;
    logic [DATA_W-1:0]  res_r_q;
    logic [CW-1:0]      wait_q;
    logic               primed_q;
    logic               overrun_q;
    logic               underrun_q;
    logic               fault_q;
    logic               write_q;

    logic               timeout;
    logic               fifo_push;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push_ok;
    pair_t              push_pair;
    pair_t              head_pair;

    assign timeout = (wait_q == CW'(MAX_WAIT - 1));

    assign read = ~reset & (state_q == S_IDLE) & read_ready;

    // write drops for one cycle after each pulse, even with write_ready held.
    assign write = ~reset & write_ready & ~write_q;

    assign writedata_left  = (write & ~fifo_empty) ? head_pair.left  : '0;
    assign writedata_right = (write & ~fifo_empty) ? head_pair.right : '0;

    assign filt_start = (state_q == S_START_L) | (state_q == S_START_R);
    assign filt_sel   = (state_q == S_START_R) ? CH_RIGHT : CH_LEFT;
    assign filt_in    = (state_q == S_START_L) ? smp_l_q :
                        (state_q == S_START_R) ? smp_r_q : '0;

    assign fifo_push       = (state_q == S_PUSH);
    assign push_pair.left  = res_l_q;
    assign push_pair.right = res_r_q;
    assign push_ok         = ~fifo_full | (write & ~fifo_empty);

    assign overrun    = overrun_q;
    assign underrun   = underrun_q;
    assign filt_fault = fault_q;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= S_IDLE;
            smp_l_q    <= '0;
            smp_r_q    <= '0;
            res_l_q    <= '0;
            res_r_q    <= '0;
            wait_q     <= '0;
            primed_q   <= 1'b0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
            fault_q    <= 1'b0;
            write_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (read_ready) begin
                        smp_l_q <= readdata_left;
                        smp_r_q <= readdata_right;
                        res_l_q <= readdata_left;
                        res_r_q <= readdata_right;
                        state_q <= bypass ? S_PUSH : S_START_L;
                    end
                end
                S_START_L: begin
                    wait_q  <= '0;
                    state_q <= S_WAIT_L;
                end
                S_WAIT_L: begin
                    if (filt_done) begin
                        res_l_q <= filt_out;
                        state_q <= S_START_R;
                    end else if (timeout) begin
                        res_l_q <= '0;
                        fault_q <= 1'b1;
                        state_q <= S_START_R;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                S_START_R: begin
                    wait_q  <= '0;
                    state_q <= S_WAIT_R;
                end
                S_WAIT_R: begin
                    if (filt_done) begin
                        res_r_q <= filt_out;
                        state_q <= S_PUSH;
                    end else if (timeout) begin
                        res_r_q <= '0;
                        fault_q <= 1'b1;
                        state_q <= S_PUSH;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                S_PUSH: begin
                    if (push_ok) primed_q  <= 1'b1;
                    else         overrun_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase

            // Zeros before the first real pair are start-up silence, not an underrun.
            if (write & fifo_empty & primed_q) underrun_q <= 1'b1;
            write_q <= write;
        end
    end

    sample_pair_fifo #(
        .T     (pair_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (CLOCK_50),
        .reset    (reset),
        .push     (fifo_push),
        .push_dat (push_pair),
        .pop      (write),
        .head_dat (head_pair),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

endmodule
